// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory stage.
// Contents: major opcodes, load/store funct3 codes, memory-stage FSM state
// encoding and a helper that decides whether a load/store may be issued.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 codes shared by loads and stores (B/H/W), plus unsigned loads
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // True when funct3 is legal for the access kind and the address is
  // naturally aligned for the access size.
  function automatic logic mem_op_ok(input logic       is_load,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    if (is_load)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    else
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    // funct3[1:0] is the access size for every legal code
    case (funct3[1:0])
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data formatter.
// Ports: rdata   - raw 32-bit word returned by data memory
//        addr_lo - byte offset of the access within the word
//        funct3  - load kind (LB/LH/LW/LBU/LHU)
//        result  - lane-selected, sign/zero-extended load value
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory stage.
// Non-memory results pass to writeback with one cycle of latency. Aligned,
// legal loads/stores issue one data-memory request and stall upstream until
// acknowledged or until TIMEOUT_CYCLES wait cycles elapse without an ack.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   valid_i, alu_i, pc_next_i,
//   data_i, wbaddr_i, instr_i      - EX-stage result bundle
//   stall_o                        - upstream must hold while high
//   dmem_req_o/we_o/addr_o/
//   wdata_o/be_o                   - data-memory request
//   dmem_rdata_i, dmem_ack_i       - data-memory response
//   wb_en_o, wbaddr_o, wbdata_o,
//   instr_o                        - registered writeback bundle
//   err_o                          - one-cycle error pulse
module mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  wbaddr_i,
  input  logic [31:0] instr_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        wb_en_o,
  output logic [4:0]  wbaddr_o,
  output logic [31:0] wbdata_o,
  output logic [31:0] instr_o,
  output logic        err_o
);

  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

  mem_state_t  state, state_nxt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem, is_link, op_ok;
  logic        start_mem, ack_done, timeout_hit;
  logic [8:0]  cnt_inc;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  // Transaction context captured on WAIT entry
  logic [7:0]  tmo_cnt;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] instr_q;
  logic [1:0]  addr_lo_q;
  logic        is_load_q;

  // ---- Decode of the incoming EX bundle ----
  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_mem    = is_load || is_store;
  assign is_link   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign op_ok     = mem_op_ok(is_load, funct3, alu_i[1:0]);
  assign start_mem = (state == ST_IDLE) && valid_i && is_mem && op_ok;

  // Timeout fires on the wait cycle that would bring the count to the limit;
  // an ack in that same cycle takes priority.
  assign cnt_inc     = {1'b0, tmo_cnt} + 9'd1;
  assign ack_done    = (state == ST_WAIT) && dmem_ack_i;
  assign timeout_hit = (state == ST_WAIT) && !dmem_ack_i && (cnt_inc >= TMO_LIMIT);

  // Store lane replication and byte enables
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{data_i[7:0]}};
        st_be    = 4'b0001 << alu_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{data_i[15:0]}};
        st_be    = alu_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = data_i;
        st_be    = 4'b1111;
      end
    endcase
  end

  load_align u_load_align (
    .rdata   (dmem_rdata_i),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (ld_data)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_mem) state_nxt = ST_WAIT;
      ST_WAIT: if (ack_done || timeout_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs (state only, no input path) ----
  always_comb begin
    stall_o = (state == ST_WAIT);
  end

  // ---- Registered request, writeback and error outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'h0;
      dmem_wdata_o <= 32'h0;
      dmem_be_o    <= 4'h0;
      wb_en_o      <= 1'b0;
      wbaddr_o     <= 5'h0;
      wbdata_o     <= 32'h0;
      instr_o      <= 32'h0;
      err_o        <= 1'b0;
      tmo_cnt      <= 8'h0;
      funct3_q     <= 3'h0;
      rd_q         <= 5'h0;
      instr_q      <= 32'h0;
      addr_lo_q    <= 2'h0;
      is_load_q    <= 1'b0;
    end else begin
      wb_en_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (is_mem) begin
              if (op_ok) begin
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= is_store;
                dmem_addr_o  <= {alu_i[31:2], 2'b00};
                dmem_wdata_o <= is_store ? st_wdata : 32'h0;
                dmem_be_o    <= is_store ? st_be : 4'h0;
                tmo_cnt      <= 8'h0;
                funct3_q     <= funct3;
                rd_q         <= wbaddr_i;
                instr_q      <= instr_i;
                addr_lo_q    <= alu_i[1:0];
                is_load_q    <= is_load;
              end else begin
                err_o <= 1'b1;
              end
            end else begin
              wbdata_o <= is_link ? pc_next_i : alu_i;
              wbaddr_o <= wbaddr_i;
              instr_o  <= instr_i;
              wb_en_o  <= (wbaddr_i != 5'd0) && (opcode != OPC_BRANCH);
            end
          end
        end
        ST_WAIT: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            wbaddr_o   <= rd_q;
            instr_o    <= instr_q;
            if (is_load_q) wbdata_o <= ld_data;
            wb_en_o    <= is_load_q && (rd_q != 5'd0);
          end else if (timeout_hit) begin
            dmem_req_o <= 1'b0;
            err_o      <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_OP     = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] alu_i = '0, pc_next_i = '0, data_i = '0, instr_i = '0;
  logic [4:0]  wbaddr_i = '0;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic        wb_en_o;
  logic [4:0]  wbaddr_o;
  logic [31:0] wbdata_o, instr_o;
  logic        err_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [4:0]  exp_rd[$];
  logic [31:0] exp_data[$];

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .alu_i(alu_i),
    .pc_next_i(pc_next_i), .data_i(data_i), .wbaddr_i(wbaddr_i),
    .instr_i(instr_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .wb_en_o(wb_en_o), .wbaddr_o(wbaddr_o), .wbdata_o(wbdata_o),
    .instr_o(instr_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'h0, f3, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] dat, input logic [31:0] pcn);
    valid_i   = 1'b1;
    instr_i   = ins;
    alu_i     = alu;
    data_i    = dat;
    pc_next_i = pcn;
    wbaddr_i  = ins[11:7];
    tick();
    valid_i   = 1'b0;
  endtask

  // Ack arrives in wait cycle n; returns number of cycles stall was seen high
  task automatic wait_ack(input int n, input logic [31:0] rdata, output int scount);
    scount = 0;
    for (int i = 1; i <= n; i++) begin
      if (stall_o) scount++;
      if (i == n) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
      end
      tick();
      dmem_ack_i = 1'b0;
    end
  endtask

  // Scoreboard: every writeback the DUT produces must match the next expected one
  always @(negedge clk) begin
    if (!reset && wb_en_o) begin
      if (exp_data.size() == 0) begin
        chk("sb_unexpected_wb", {27'h0, wbaddr_o}, 32'hFFFF_FFFF);
      end else begin
        logic [4:0]  r;
        logic [31:0] d;
        r = exp_rd.pop_front();
        d = exp_data.pop_front();
        chk("sb_wbaddr", {27'h0, wbaddr_o}, {27'h0, r});
        chk("sb_wbdata", wbdata_o, d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int req_cnt;

    // Reset state
    tick(); tick();
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_we", {31'h0, dmem_we_o}, 32'h0);
    chk("rst_be", {28'h0, dmem_be_o}, 32'h0);
    chk("rst_wb_en", {31'h0, wb_en_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_wbdata", wbdata_o, 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    reset = 1'b0;
    tick();

    // ALU op, rd=5
    exp_rd.push_back(5'd5); exp_data.push_back(32'h0000_1234);
    issue(mk(T_OP, 3'b000, 5'd5), 32'h0000_1234, 32'h0, 32'h0);
    chk("alu_wb_en", {31'h0, wb_en_o}, 32'h1);
    chk("alu_wbaddr", {27'h0, wbaddr_o}, 32'd5);
    tick();
    chk("idle_wb_en", {31'h0, wb_en_o}, 32'h0);

    // JAL writes link value; BRANCH and rd=0 do not write back
    exp_rd.push_back(5'd1); exp_data.push_back(32'h0000_0044);
    issue(mk(T_JAL, 3'b000, 5'd1), 32'h0000_0999, 32'h0, 32'h0000_0044);
    chk("jal_wbdata", wbdata_o, 32'h0000_0044);
    issue(mk(T_BRANCH, 3'b000, 5'd3), 32'h1, 32'h0, 32'h0);
    chk("branch_wb_en", {31'h0, wb_en_o}, 32'h0);
    issue(mk(T_OP, 3'b000, 5'd0), 32'h55, 32'h0, 32'h0);
    chk("rd0_wb_en", {31'h0, wb_en_o}, 32'h0);
    tick();

    // LB at 0x103, ack in 3rd wait cycle
    exp_rd.push_back(5'd7); exp_data.push_back(32'hFFFF_FF80);
    issue(mk(T_LOAD, 3'b000, 5'd7), 32'h0000_0103, 32'h0, 32'h0);
    chk("lb_req", {31'h0, dmem_req_o}, 32'h1);
    chk("lb_addr", dmem_addr_o, 32'h0000_0100);
    chk("lb_we", {31'h0, dmem_we_o}, 32'h0);
    wait_ack(3, 32'h80FF_0000, sc);
    chk("lb_stall_cycles", sc, 32'd3);
    chk("lb_stall_low", {31'h0, stall_o}, 32'h0);
    chk("lb_req_low", {31'h0, dmem_req_o}, 32'h0);
    chk("lb_wb_en", {31'h0, wb_en_o}, 32'h1);

    // LBU same address
    exp_rd.push_back(5'd8); exp_data.push_back(32'h0000_0080);
    issue(mk(T_LOAD, 3'b100, 5'd8), 32'h0000_0103, 32'h0, 32'h0);
    wait_ack(3, 32'h80FF_0000, sc);
    chk("lbu_stall_cycles", sc, 32'd3);

    // LH at 0x102 and LHU at 0x100, minimum latency
    exp_rd.push_back(5'd11); exp_data.push_back(32'hFFFF_80FF);
    issue(mk(T_LOAD, 3'b001, 5'd11), 32'h0000_0102, 32'h0, 32'h0);
    wait_ack(1, 32'h80FF_9234, sc);
    exp_rd.push_back(5'd12); exp_data.push_back(32'h0000_9234);
    issue(mk(T_LOAD, 3'b101, 5'd12), 32'h0000_0100, 32'h0, 32'h0);
    wait_ack(1, 32'h80FF_9234, sc);
    chk("lhu_stall_cycles", sc, 32'd1);

    // SH at 0x102
    issue(mk(T_STORE, 3'b001, 5'd0), 32'h0000_0102, 32'h0000_ABCD, 32'h0);
    chk("sh_be", {28'h0, dmem_be_o}, 32'h0000_000C);
    chk("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
    chk("sh_addr", dmem_addr_o, 32'h0000_0100);
    chk("sh_we", {31'h0, dmem_we_o}, 32'h1);
    chk("sh_stall", {31'h0, stall_o}, 32'h1);
    wait_ack(2, 32'h0, sc);
    chk("sh_wb_en", {31'h0, wb_en_o}, 32'h0);
    chk("sh_stall_low", {31'h0, stall_o}, 32'h0);

    // SB at 0x101, SW at 0x200
    issue(mk(T_STORE, 3'b000, 5'd0), 32'h0000_0101, 32'h1234_565A, 32'h0);
    chk("sb_be", {28'h0, dmem_be_o}, 32'h0000_0002);
    chk("sb_wdata", dmem_wdata_o, 32'h5A5A_5A5A);
    wait_ack(1, 32'h0, sc);
    issue(mk(T_STORE, 3'b010, 5'd0), 32'h0000_0200, 32'hCAFE_F00D, 32'h0);
    chk("sw_be", {28'h0, dmem_be_o}, 32'h0000_000F);
    chk("sw_wdata", dmem_wdata_o, 32'hCAFE_F00D);
    wait_ack(1, 32'h0, sc);

    // Misaligned LW and illegal LOAD funct3
    issue(mk(T_LOAD, 3'b010, 5'd4), 32'h0000_0102, 32'h0, 32'h0);
    chk("mis_req", {31'h0, dmem_req_o}, 32'h0);
    chk("mis_err", {31'h0, err_o}, 32'h1);
    chk("mis_stall", {31'h0, stall_o}, 32'h0);
    chk("mis_wb_en", {31'h0, wb_en_o}, 32'h0);
    tick();
    chk("mis_err_pulse", {31'h0, err_o}, 32'h0);
    issue(mk(T_LOAD, 3'b011, 5'd4), 32'h0000_0100, 32'h0, 32'h0);
    chk("ill_err", {31'h0, err_o}, 32'h1);
    chk("ill_req", {31'h0, dmem_req_o}, 32'h0);
    tick();

    // LW timeout, no ack
    issue(mk(T_LOAD, 3'b010, 5'd9), 32'h0000_0040, 32'h0, 32'h0);
    req_cnt = 0;
    for (int i = 0; i < 8 && dmem_req_o; i++) begin
      req_cnt++;
      tick();
    end
    chk("tmo_req_cycles", req_cnt, 32'd4);
    chk("tmo_err", {31'h0, err_o}, 32'h1);
    chk("tmo_stall", {31'h0, stall_o}, 32'h0);
    chk("tmo_wb_en", {31'h0, wb_en_o}, 32'h0);
    tick();
    chk("tmo_err_pulse", {31'h0, err_o}, 32'h0);

    // LW with ack on the 4th wait cycle: ack wins
    exp_rd.push_back(5'd9); exp_data.push_back(32'hDEAD_BEEF);
    issue(mk(T_LOAD, 3'b010, 5'd9), 32'h0000_0040, 32'h0, 32'h0);
    wait_ack(4, 32'hDEAD_BEEF, sc);
    chk("ack4_stall_cycles", sc, 32'd4);
    chk("ack4_err", {31'h0, err_o}, 32'h0);
    chk("ack4_wb_en", {31'h0, wb_en_o}, 32'h1);
    tick();

    // Reset in the 2nd wait cycle, late ack afterwards
    issue(mk(T_LOAD, 3'b010, 5'd10), 32'h0000_0080, 32'h0, 32'h0);
    tick();
    chk("rw_stall_before", {31'h0, stall_o}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rw_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rw_stall", {31'h0, stall_o}, 32'h0);
    tick();
    reset = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h1111_2222;
    tick();
    dmem_ack_i = 1'b0;
    chk("late_ack_wb_en", {31'h0, wb_en_o}, 32'h0);
    chk("late_ack_stall", {31'h0, stall_o}, 32'h0);
    chk("late_ack_req", {31'h0, dmem_req_o}, 32'h0);
    tick(); tick();

    chk("sb_drained", exp_data.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max WAIT cycles without dmem_ack_i before abort (range 1..255).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 valid_i  in  1  EX result valid this cycle.
REQ-005 alu_i  in  32  EX ALU result; effective address for loads/stores.
REQ-006 pc_next_i  in  32  link value for JAL/JALR.
REQ-007 data_i  in  32  forwarded rs2 store data.
REQ-008 wbaddr_i  in  5  destination register.
REQ-009 instr_i  in  32  instruction word.
REQ-010 stall_o  out  1  upstream SHALL hold all inputs stable while high.
REQ-011 dmem_req_o, dmem_we_o  out  1 each  memory request / write.
REQ-012 dmem_addr_o  out  32  word-aligned address ({alu[31:2],2'b00}).
REQ-013 dmem_wdata_o  out  32; dmem_be_o  out  4  lane-replicated store data, byte enables.
REQ-014 dmem_rdata_i  in  32; dmem_ack_i  in  1  read data, completion (valid only while dmem_req_o high).
REQ-015 wb_en_o  out  1; wbaddr_o  out  5; wbdata_o  out  32; instr_o  out  32  registered writeback bundle to WB and EX forwarding (past1).
REQ-016 err_o  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.

Function
REQ-017 Opcodes: LOAD 0000011, STORE 0100011, JAL 1101111, JALR 1100111, BRANCH 1100011.
REQ-018 FSM states IDLE, WAIT; reset state IDLE.
REQ-019 IDLE, valid_i=0: next cycle wb_en_o=0, other outputs hold.
REQ-020 IDLE, valid_i=1, non-memory opcode: one-cycle latency; next edge registers wbdata_o = pc_next_i for JAL/JALR, else alu_i; wb_en_o=1 iff wbaddr_i!=0 and opcode not STORE/BRANCH.
REQ-021 IDLE, valid_i=1, LOAD/STORE aligned with legal funct3: capture address/data/funct3/rd/instr internally, go WAIT; dmem_req_o registered high from first WAIT cycle.
REQ-022 Misalignment: halfword with alu[0]=1; word with alu[1:0]!=0; illegal funct3 (LOAD: 011,110,111; STORE: >010): no request, err_o pulse next cycle, wb_en_o=0, stay IDLE.
REQ-023 WAIT: stall_o=1, dmem_req_o=1, wb_en_o=0; dmem_addr_o/we/wdata/be constant.
REQ-024 WAIT with dmem_ack_i=1: next edge dmem_req_o=0, state IDLE, stall_o=0, wb_en_o=1 for LOAD with rd!=0 (0 for STORE); minimum memory-op latency 2 cycles.
REQ-025 Load format by funct3 and addr[1:0]: LB/LBU byte lane addr[1:0], LH/LHU halfword lane addr[1], LW full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 Store enables: SB 0001<<addr[1:0], data byte replicated x4; SH 0011<<(2*addr[1]), halfword replicated x2; SW 1111.
REQ-027 Timeout: 8-bit counter cleared on WAIT entry, increments each WAIT cycle without ack; reaching TIMEOUT_CYCLES: drop request, err_o pulse, wb_en_o=0, IDLE.
REQ-028 Ack on the same cycle counter reaches TIMEOUT_CYCLES: ack wins, normal completion, no err_o.
REQ-029 dmem_ack_i in IDLE: ignored.
REQ-030 stall_o is combinational from state only (no input-to-stall path).

Reset
REQ-031 reset asserted: immediately state=IDLE, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, stall_o=0, wb_en_o=0, err_o=0, counter=0, wbdata_o/wbaddr_o/instr_o/dmem_addr_o/dmem_wdata_o=0.
REQ-032 Reset mid-WAIT abandons transaction; late ack after release ignored.

Structure
REQ-033 Shared package riscv_pkg: opcode constants, funct3 load/store codes, mem-stage state enum.
REQ-034 One combinational sub-module load_align: (rdata, addr[1:0], funct3) -> formatted 32-bit result.

Verification
REQ-035 ALU op, alu_i=0x0000_1234, rd=5 -> next cycle wb_en_o=1, wbaddr_o=5, wbdata_o=0x0000_1234.
REQ-036 LB at 0x103, ack after 3 WAIT cycles, rdata=0x80FF_0000 -> stall_o high 3 cycles, wbdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-037 SH at 0x102, data_i=0x0000_ABCD -> dmem_be_o=1100, dmem_wdata_o=0xABCD_ABCD, dmem_addr_o=0x100, wb_en_o=0.
REQ-038 LW at 0x102 -> no dmem_req_o, err_o pulse, wb_en_o=0.
REQ-039 LW, no ack, TIMEOUT_CYCLES=4 -> req high 4 cycles, err_o pulse, stall_o falls; ack on 4th cycle -> normal completion, no err_o.
REQ-040 reset in 2nd WAIT cycle -> dmem_req_o, stall_o low same cycle; ack after release -> no wb_en_o.
